// File: rtl/xy_frame_streamer.sv
// Streams NCH lanes of buffered X/Y point samples as clocked serial bytes with START/STOP framing.
// Optional macro XYS_INVERT_EN: invert point samples on lanes selected by INV_MASK.
module xy_frame_streamer #(
   parameter int unsigned    DATA_W   = 8,
   parameter int unsigned    NCH      = 2,
   parameter int unsigned    ADDR_W   = 11,
   parameter int unsigned    CLK_DIV  = 4,
   parameter logic [7:0]     HDR0     = 8'h90,
   parameter logic [7:0]     HDR1     = 8'h40,
   parameter logic [NCH-1:0] INV_MASK = 2'b10
) (
   input  logic                  clk,
   input  logic                  N_rst,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [NCH*DATA_W-1:0] wr_data,
   input  logic [ADDR_W:0]       frame_len,
   input  logic                  start,
   input  logic                  loop,
   input  logic                  stop_req,
   output logic                  scl,
   output logic [NCH-1:0]        sda,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam int unsigned BIT_W = $clog2(DATA_W + 1);
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      StIdle, StStart, StHdr0, StHdr1, StPts, StStop
   } state_e;

   state_e                          state_q, state_d;
   logic [DIV_W-1:0]                div_q, div_d;
   logic                            phase_q, phase_d;  // 0 = scl low half, 1 = scl high half
   logic [BIT_W-1:0]                bit_q, bit_d;      // DATA_W..1 data bits, 0 = ack slot
   logic                            stop_q, stop_d;
   logic [ADDR_W-1:0]               p_q, p_d;
   logic [ADDR_W:0]                 len_q, len_d;
   logic [NCH-1:0][DATA_W-1:0]      lane_q, lane_d;
   logic                            done_q, done_d;

   logic [NCH*DATA_W-1:0]           mem [2**ADDR_W];
   logic [NCH*DATA_W-1:0]           rd_q;
   logic                            rd_en;
   logic [ADDR_W-1:0]               rd_addr;
   logic [NCH-1:0][DATA_W-1:0]      pt_word;

   logic                            div_last;
   logic                            in_slot;
   logic                            byte_end;
   logic                            last_pt;
   logic                            stop_now;
   logic [ADDR_W:0]                 len_clamp;

   // Point buffer: no reset so contents survive N_rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_q <= mem[rd_addr];
      end
   end

   assign div_last  = (div_q == DIV_W'(CLK_DIV - 1));
   assign in_slot   = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StPts);
   assign byte_end  = in_slot && div_last && phase_q && (bit_q == '0);
   assign last_pt   = ({1'b0, p_q} == (len_q - 1'b1));
   assign stop_now  = stop_q | stop_req;
   assign len_clamp = (frame_len > DEPTH) ? DEPTH : frame_len;

   // Next point is fetched throughout the ack slot so it is ready at the byte boundary.
   assign rd_en   = in_slot && (bit_q == '0);
   assign rd_addr = ((state_q == StPts) && !last_pt) ? (p_q + 1'b1) : '0;

`ifdef XYS_INVERT_EN
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         pt_word[k] = INV_MASK[k] ? ~rd_q[k*DATA_W +: DATA_W] : rd_q[k*DATA_W +: DATA_W];
      end
   end
`else
   logic unused_inv_mask;
   assign unused_inv_mask = ^INV_MASK;

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         pt_word[k] = rd_q[k*DATA_W +: DATA_W];
      end
   end
`endif

   always_ff @(posedge clk or negedge N_rst) begin
      if (!N_rst) begin
         state_q <= StIdle;
         div_q   <= '0;
         phase_q <= 1'b1;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         p_q     <= '0;
         len_q   <= '0;
         lane_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         p_q     <= p_d;
         len_q   <= len_d;
         lane_q  <= lane_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      p_d     = p_q;
      len_d   = len_q;
      lane_d  = lane_q;
      done_d  = 1'b0;

      if ((state_q != StIdle) && stop_req) begin
         stop_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (start && (frame_len != '0)) begin
               state_d = StStart;
               len_d   = len_clamp;
               div_d   = '0;
               phase_d = 1'b1;
               stop_d  = 1'b0;
            end
         end

         StStart: begin
            div_d = div_last ? '0 : div_q + 1'b1;
            if (div_last) begin
               state_d = StHdr0;
               phase_d = 1'b0;
               bit_d   = BIT_W'(DATA_W);
               for (int k = 0; k < NCH; k++) begin
                  lane_d[k] = DATA_W'(HDR0);
               end
            end
         end

         StHdr0, StHdr1, StPts: begin
            if (div_last) begin
               div_d   = '0;
               phase_d = ~phase_q;
               // Leaving a high half: advance to the next bit and expose it on the MSB.
               if (phase_q && (bit_q != '0)) begin
                  bit_d = bit_q - 1'b1;
                  for (int k = 0; k < NCH; k++) begin
                     lane_d[k] = {lane_q[k][DATA_W-2:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end

            if (byte_end) begin
               phase_d = 1'b0;
               bit_d   = BIT_W'(DATA_W);
               if (stop_now) begin
                  state_d = StStop;
               end else begin
                  case (state_q)
                     StHdr0: begin
                        state_d = StHdr1;
                        for (int k = 0; k < NCH; k++) begin
                           lane_d[k] = DATA_W'(HDR1);
                        end
                     end
                     StHdr1: begin
                        state_d = StPts;
                        p_d     = '0;
                        lane_d  = pt_word;
                     end
                     default: begin
                        if (!last_pt) begin
                           p_d    = p_q + 1'b1;
                           lane_d = pt_word;
                        end else if (loop) begin
                           // Shape-switch point: a zero frame_len keeps the current length.
                           p_d    = '0;
                           lane_d = pt_word;
                           if (frame_len != '0) begin
                              len_d = len_clamp;
                           end
                        end else begin
                           state_d = StStop;
                        end
                     end
                  endcase
               end
            end
         end

         StStop: begin
            div_d = div_last ? '0 : div_q + 1'b1;
            if (div_last) begin
               if (phase_q) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                  stop_d  = 1'b0;
               end else begin
                  phase_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      scl = 1'b1;
      sda = '1;
      case (state_q)
         StStart: begin
            sda = '0;
         end
         StHdr0, StHdr1, StPts: begin
            scl = phase_q;
            for (int k = 0; k < NCH; k++) begin
               sda[k] = (bit_q == '0) ? 1'b1 : lane_q[k][DATA_W-1];
            end
         end
         StStop: begin
            scl = phase_q;
            sda = '0;
         end
         default: begin
            scl = 1'b1;
            sda = '1;
         end
      endcase
   end

   assign busy       = (state_q != StIdle);
   assign frame_done = done_q;

endmodule

// File: doc/xy_frame_streamer.md
Name: xy_frame_streamer

Overview:
- Parametrised successor to the oscilloscope point serializer: streams NCH parallel channels of DATA_W-bit point samples out as synchronous serial lanes sharing one generated clock (scl).
- Point data lives in an internal dual-port buffer that is written at run time, replacing fixed per-shape file loads.
- Adds start/stop framing, one-shot or looped playback, a live frame-length switch at loop wrap, and busy/done status.
- Sits between the shape loader/host logic and the dual DAC lanes driving the scope X/Y inputs.

Parameters:
- DATA_W, 8, bits per sample per channel.
- NCH, 2, number of serial lanes (channel 0 = X, channel 1 = Y).
- ADDR_W, 11, buffer address width; depth = 2**ADDR_W points.
- CLK_DIV, 4, clk cycles per scl half-period; legal values ≥2.
- HDR0, 8'h90, first header byte sent on every lane after START.
- HDR1, 8'h40, second header byte sent on every lane after HDR0.
- INV_MASK, 2'b10, per-lane inversion mask; used only with XYS_INVERT_EN.

Ports:
- clk  in  1  system clock.
- N_rst  in  1  asynchronous active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  ADDR_W  buffer write address.
- wr_data  in  NCH*DATA_W  packed point; lane k occupies bits [k*DATA_W +: DATA_W].
- frame_len  in  ADDR_W+1  number of points in the frame, 0..2**ADDR_W.
- start  in  1  level or pulse; sampled only in IDLE.
- loop  in  1  1 = replay points after the last one; 0 = one-shot.
- stop_req  in  1  pulse; ends playback after the current byte.
- scl  out  1  generated serial clock.
- sda  out  NCH  serial data lanes.
- busy  out  1  high from leaving IDLE until STOP completes.
- frame_done  out  1  one-cycle pulse when returning to IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - Outputs: scl=1, sda=all 1, busy=0, frame_done=0.
  - FSM enters IDLE; the divider, bit counter and stop latch clear.
  - Buffer contents are not cleared.
- Writes:
  - Buffer write occurs on the posedge clk with wr_en=1 and is legal in every state.
  - The read is synchronous with 1-cycle latency. A write to the address currently being fetched is visible on the next fetch of that address.
- States: IDLE -> START -> HDR0 -> HDR1 -> PTS -> STOP -> IDLE.
- IDLE:
  - On start=1 and frame_len≠0, latch len=min(frame_len, 2**ADDR_W), set busy=1 next cycle, and go to START.
  - start with frame_len=0 is ignored.
- START: sda=all 0 with scl=1 held for CLK_DIV cycles, then scl falls.
- Byte slot:
  - 9 bit periods: 8 data bits MSB first, then 1 ack slot with sda=all 1 (lines released, ack not checked).
  - Each bit period is CLK_DIV cycles scl low followed by CLK_DIV cycles scl high.
  - sda changes only on the first clk of the scl-low phase and is stable for the whole scl-high phase.
  - Byte period = 18*CLK_DIV clk cycles.
- HDR0 / HDR1: every lane sends the same header byte.
- PTS:
  - Point index p starts at 0; lane k sends buffer[p][k].
  - The next point is fetched during the ack slot of the current byte.
  - After point len-1:
    - loop=1 and no pending stop: p wraps to 0 with no headers, and frame_len is re-sampled into len (the shape-switch point; a 0 value keeps the old len).
    - Otherwise go to STOP.
- stop_req:
  - Latched in any busy state.
  - Takes effect at the end of the current byte slot, including header slots; the FSM then goes to STOP.
  - Ignored in IDLE.
- STOP: sda=all 0 with scl low for CLK_DIV cycles, then scl=1 for CLK_DIV cycles, then sda=all 1. Next cycle: busy=0, frame_done=1 for one cycle, FSM in IDLE.
- Simultaneous start with stop_req in IDLE: start wins.
- The counters never overflow: the divider counts 0..CLK_DIV-1 and the bit counter counts 8..0.

Optional Feature:
- Macro XYS_INVERT_EN.
- Defined: lanes whose INV_MASK bit is set send the bitwise-NOT of the sample (equal to 2**DATA_W-1 minus the sample), correcting the display's vertical flip. Headers are never inverted.
- Undefined: samples are sent unmodified, INV_MASK is ignored, and no inversion logic is built.

Test Plan:
- Reset and idle, CLK_DIV=2: assert N_rst=0 mid-PTS -> in the same cycle scl=1, sda=2'b11, busy=0; buffer word 0 unchanged after release.
- One-shot, len=1, buffer[0]={8'h3C,8'hA5}, loop=0: START, then lane0 bits 90,40,A5 and lane1 bits 90,40,3C; each byte followed by an ack bit of 1; then STOP. frame_done pulses once exactly 2+3*36+4 cycles after leaving IDLE (START 2 cycles, three 36-cycle bytes, STOP 4 cycles).
- Loop and wrap, len=3, loop=1: point order 0,1,2,0,1 with no header between 2 and 0. Set frame_len=2 mid-frame -> after the wrap the order is 0,1,0,1.
- stop_req during the second data bit of HDR1 -> HDR1 completes including its ack slot, then STOP; no point bytes are sent.
- start with frame_len=0 -> busy stays 0 and scl stays 1 for 100 cycles; frame_len=2**ADDR_W+5 is clamped to 2048 points.
- XYS_INVERT_EN defined, INV_MASK=2'b10, sample lane1=8'h10 -> lane1 sends 8'hEF, lane0 unchanged, headers 90/40 on both lanes.
